// File: rtl/pru_instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : pru_instr_loader
// Brief    : Streams a program into the ping/pong instruction banks and
//            sequences execution enable and bank refills.
// Revision : 1.0
// ============================================================================
module pru_instr_loader #(
    parameter int INSTR_W = 32,
    parameter int BANK_AW = 8,
    parameter int LEN_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   prog_len,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [INSTR_W-1:0] s_instr,
    input  logic [BANK_AW:0]   current_instr_rd_addr,
    output logic [INSTR_W-1:0] init_instr,
    output logic [BANK_AW:0]   init_instr_addr,
    output logic               init_instr_we,
    output logic               io_ping_wr,
    output logic               enable_execution,
    output logic               busy,
    output logic               load_done,
    output logic               len_err
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_WAIT_FREE = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    localparam logic [BANK_AW-1:0] C_OFFSET_MAX = '1;

    state_t               r_state, w_state_next;
    logic                 r_wr_bank, w_wr_bank_next;
    logic [BANK_AW-1:0]   r_offset, w_offset_next;
    logic [LEN_W-1:0]     r_words_left, w_words_left_next;
    logic                 r_prefilled, w_prefilled_next;
    logic [INSTR_W-1:0]   r_init_instr, w_init_instr_next;
    logic [BANK_AW:0]     r_init_instr_addr, w_init_instr_addr_next;
    logic                 r_init_instr_we, w_init_instr_we_next;
    logic                 r_io_ping_wr, w_io_ping_wr_next;
    logic                 r_enable_execution, w_enable_execution_next;
    logic                 r_len_err, w_len_err_next;
    logic                 w_handshake;
    logic                 w_unused_rd_offset;

    // Only the bank bit of the read pointer matters to the refill decision.
    assign w_unused_rd_offset = ^current_instr_rd_addr[BANK_AW-1:0];

    assign w_handshake = s_valid && (r_state == ST_FILL);

    always_comb begin
        w_state_next            = r_state;
        w_wr_bank_next          = r_wr_bank;
        w_offset_next           = r_offset;
        w_words_left_next       = r_words_left;
        w_prefilled_next        = r_prefilled;
        w_init_instr_next       = r_init_instr;
        w_init_instr_addr_next  = r_init_instr_addr;
        w_init_instr_we_next    = 1'b0;
        w_io_ping_wr_next       = r_io_ping_wr;
        w_enable_execution_next = r_enable_execution;
        w_len_err_next          = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (prog_len != '0) begin
                        w_words_left_next       = prog_len;
                        w_wr_bank_next          = 1'b0;
                        w_offset_next           = '0;
                        w_prefilled_next        = 1'b0;
                        w_enable_execution_next = 1'b0;
                        w_state_next            = ST_FILL;
                    end else begin
                        w_len_err_next = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (w_handshake) begin
                    w_init_instr_next      = s_instr;
                    w_init_instr_addr_next = {r_wr_bank, r_offset};
                    w_io_ping_wr_next      = ~r_wr_bank;
                    w_init_instr_we_next   = 1'b1;
                    w_offset_next          = r_offset + 1'b1;
                    w_words_left_next      = r_words_left - 1'b1;
                    // Offset wraps to zero naturally at the end of a bank.
                    if (r_words_left == LEN_W'(1)) begin
                        w_enable_execution_next = 1'b1;
                        w_state_next            = ST_DONE;
                    end else if (r_offset == C_OFFSET_MAX) begin
                        if (!r_prefilled && !r_wr_bank) begin
                            w_wr_bank_next = 1'b1;
                        end else if (!r_prefilled) begin
                            w_prefilled_next        = 1'b1;
                            w_enable_execution_next = 1'b1;
                            w_wr_bank_next          = 1'b0;
                            w_state_next            = ST_WAIT_FREE;
                        end else begin
                            w_wr_bank_next = ~r_wr_bank;
                            w_state_next   = ST_WAIT_FREE;
                        end
                    end
                end
            end
            ST_WAIT_FREE: begin
                if (current_instr_rd_addr[BANK_AW] != r_wr_bank) begin
                    w_state_next = ST_FILL;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state            <= ST_IDLE;
            r_wr_bank          <= 1'b0;
            r_offset           <= '0;
            r_words_left       <= '0;
            r_prefilled        <= 1'b0;
            r_init_instr       <= '0;
            r_init_instr_addr  <= '0;
            r_init_instr_we    <= 1'b0;
            r_io_ping_wr       <= 1'b1;
            r_enable_execution <= 1'b0;
            r_len_err          <= 1'b0;
        end else begin
            r_state            <= w_state_next;
            r_wr_bank          <= w_wr_bank_next;
            r_offset           <= w_offset_next;
            r_words_left       <= w_words_left_next;
            r_prefilled        <= w_prefilled_next;
            r_init_instr       <= w_init_instr_next;
            r_init_instr_addr  <= w_init_instr_addr_next;
            r_init_instr_we    <= w_init_instr_we_next;
            r_io_ping_wr       <= w_io_ping_wr_next;
            r_enable_execution <= w_enable_execution_next;
            r_len_err          <= w_len_err_next;
        end
    end

    assign s_ready          = (r_state == ST_FILL);
    assign busy             = (r_state == ST_FILL) || (r_state == ST_WAIT_FREE);
    assign load_done        = (r_state == ST_DONE);
    assign init_instr       = r_init_instr;
    assign init_instr_addr  = r_init_instr_addr;
    assign init_instr_we    = r_init_instr_we;
    assign io_ping_wr       = r_io_ping_wr;
    assign enable_execution = r_enable_execution;
    assign len_err          = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_pru_instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pru_instr_loader
// Brief    : Randomised program loads against a word-count model of the loader.
// Revision : 1.0
// ============================================================================
module tb_pru_instr_loader;
    localparam int INSTR_W = 32;
    localparam int BANK_AW = 2;
    localparam int LEN_W   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [LEN_W-1:0]   prog_len;
    logic               s_valid;
    logic               s_ready;
    logic [INSTR_W-1:0] s_instr;
    logic [BANK_AW:0]   current_instr_rd_addr;
    logic [INSTR_W-1:0] init_instr;
    logic [BANK_AW:0]   init_instr_addr;
    logic               init_instr_we;
    logic               io_ping_wr;
    logic               enable_execution;
    logic               busy;
    logic               load_done;
    logic               len_err;

    pru_instr_loader #(
        .INSTR_W (INSTR_W),
        .BANK_AW (BANK_AW),
        .LEN_W   (LEN_W)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .prog_len              (prog_len),
        .s_valid               (s_valid),
        .s_ready               (s_ready),
        .s_instr               (s_instr),
        .current_instr_rd_addr (current_instr_rd_addr),
        .init_instr            (init_instr),
        .init_instr_addr       (init_instr_addr),
        .init_instr_we         (init_instr_we),
        .io_ping_wr            (io_ping_wr),
        .enable_execution      (enable_execution),
        .busy                  (busy),
        .load_done             (load_done),
        .len_err               (len_err)
    );

    always #5 clk = ~clk;

    int checks     = 0;
    int failures   = 0;
    int dut_writes = 0;

    // Reference model in program terms: word k lands at k mod 8 of the two
    // 4-word banks; every bank after the first two waits for the reader.
    bit          m_loading = 1'b0;
    bit          m_ready   = 1'b0;
    bit          m_we      = 1'b0;
    bit          m_ping    = 1'b1;
    bit          m_en      = 1'b0;
    bit          m_done    = 1'b0;
    bit          m_len_err = 1'b0;
    bit          m_target  = 1'b0;
    int          m_len     = 0;
    int          m_cnt     = 0;
    logic [31:0] m_data    = '0;
    logic [2:0]  m_addr    = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit          hs, st, rv, rdb;
        logic [31:0] d;
        int          pl;
        hs  = s_valid && m_ready;
        st  = start;
        rv  = rst;
        rdb = current_instr_rd_addr[BANK_AW];
        d   = s_instr;
        pl  = int'(prog_len);
        @(posedge clk);
        #1;
        m_we      = 1'b0;
        m_len_err = 1'b0;
        if (!rv) begin
            m_loading = 1'b0; m_ready = 1'b0; m_en = 1'b0; m_done = 1'b0;
            m_data = '0; m_addr = '0; m_ping = 1'b1;
        end else if (!m_loading) begin
            if (st) begin
                if (pl == 0) begin
                    m_len_err = 1'b1;
                end else begin
                    m_len = pl; m_cnt = 0; m_loading = 1'b1; m_ready = 1'b1;
                    m_en = 1'b0; m_done = 1'b0;
                end
            end
        end else if (hs) begin
            m_we   = 1'b1;
            m_addr = 3'(m_cnt % 8);
            m_ping = ((m_cnt / 4) % 2) == 0;
            m_data = d;
            m_cnt++;
            if (m_cnt == m_len) begin
                m_loading = 1'b0; m_ready = 1'b0; m_en = 1'b1; m_done = 1'b1;
            end else begin
                if (m_cnt == 8) m_en = 1'b1;
                if (m_cnt % 4 == 0 && m_cnt >= 8) begin
                    m_ready  = 1'b0;
                    m_target = ((m_cnt / 4) % 2) == 1;
                end
            end
        end else if (!m_ready && rdb != m_target) begin
            m_ready = 1'b1;
        end
        dut_writes += int'(init_instr_we);
        check("s_ready",          32'(s_ready),          32'(m_ready));
        check("busy",             32'(busy),             32'(m_loading));
        check("init_instr_we",    32'(init_instr_we),    32'(m_we));
        check("init_instr",       init_instr,            m_data);
        check("init_instr_addr",  32'(init_instr_addr),  32'(m_addr));
        check("io_ping_wr",       32'(io_ping_wr),       32'(m_ping));
        check("enable_execution", 32'(enable_execution), 32'(m_en));
        check("load_done",        32'(load_done),        32'(m_done));
        check("len_err",          32'(len_err),          32'(m_len_err));
    endtask

    task automatic run_prog(input int len, input int valid_pct, input bit toggle,
                            input bit start_noise, input int hold);
        int budget = 0;
        int waited = 0;
        start    = 1'b1;
        prog_len = 16'(len);
        s_valid  = 1'b0;
        cycle();
        start = 1'b0;
        while (m_loading && budget < 2000) begin
            budget++;
            s_valid  = toggle ? budget[0] : ($urandom_range(99) < valid_pct);
            s_instr  = $urandom;
            start    = start_noise ? 1'($urandom_range(1)) : 1'b0;
            prog_len = 16'($urandom_range(20));
            if (!m_ready) begin
                if (waited < hold) begin
                    current_instr_rd_addr = {m_target, 2'($urandom_range(3))};
                    waited++;
                end else begin
                    current_instr_rd_addr = {~m_target, 2'($urandom_range(3))};
                end
            end else begin
                waited = 0;
                current_instr_rd_addr = 3'($urandom_range(7));
            end
            cycle();
        end
        start   = 1'b0;
        s_valid = 1'b0;
        checks++;
        assert (budget < 2000) else begin
            failures++;
            $error("FAIL load_timeout observed=%0d expected=<2000", budget);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; prog_len = '0; s_valid = 1'b0;
        s_instr = '0; current_instr_rd_addr = '0;

        // Reset held with random inputs.
        repeat (3) begin
            start    = 1'($urandom_range(1));
            s_valid  = 1'($urandom_range(1));
            s_instr  = $urandom;
            prog_len = 16'($urandom_range(20));
            current_instr_rd_addr = 3'($urandom_range(7));
            cycle();
        end
        rst = 1'b1; start = 1'b0; s_valid = 1'b0;
        cycle();

        run_prog(3, 100, 1'b0, 1'b0, 0);
        cycle();
        run_prog(8, 100, 1'b0, 1'b0, 0);
        cycle();
        run_prog(10, 100, 1'b0, 1'b0, 4);
        cycle();

        dut_writes = 0;
        run_prog(5, 0, 1'b1, 1'b1, 0);
        cycle();
        check("prog5_write_count", 32'(dut_writes), 32'd5);

        // Zero-length request from DONE.
        start = 1'b1; prog_len = '0;
        cycle();
        start = 1'b0;
        cycle();

        run_prog(1, 100, 1'b0, 1'b0, 0);
        cycle();

        // Reset after two of six words.
        start = 1'b1; prog_len = 16'd6;
        cycle();
        start = 1'b0;
        while (m_cnt < 2) begin
            s_valid = 1'b1; s_instr = $urandom;
            cycle();
        end
        rst = 1'b0; s_valid = 1'b1; s_instr = $urandom;
        cycle();
        rst = 1'b1;
        dut_writes = 0;
        repeat (3) cycle();
        check("post_reset_writes", 32'(dut_writes), 32'd0);
        s_valid = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_prog($urandom_range(1, 30), $urandom_range(30, 100), 1'b0,
                     1'($urandom_range(1)), $urandom_range(0, 3));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
